pmem_burst_sequencer: RTL and testbench
=======================================

Name: pmem_burst_sequencer

Overview:
- Sits between the L2-side memory arbiter and physical memory; owns the main-memory port.
- Converts one 256-bit cacheline read or write request into a fixed burst of 64-bit beats on the memory bus.
- Returns a single-cycle line response once the burst completes.
- The arbiter in front of it holds a request until response, then may present the next requester's request on the following cycle.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits; must be a multiple of BEAT_WIDTH.
- BEAT_WIDTH, 64, memory bus data width in bits.
- BEATS, LINE_WIDTH/BEAT_WIDTH (4), derived beats per line; localparam, not overridable.
- OFFSET_BITS, $clog2(LINE_WIDTH/8) (5), derived byte-offset bits cleared in burst address.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- pmem_read_cla  in  1  line read request, held until pmem_resp_cla.
- pmem_write_cla  in  1  line write request, held until pmem_resp_cla.
- pmem_address_cla  in  32  line address.
- pmem_wdata_256_cla  in  LINE_WIDTH  write line data.
- pmem_resp_cla  out  1  one-cycle completion pulse.
- pmem_rdata_256_cla  out  LINE_WIDTH  assembled read line.
- burst_read  out  1  memory read, held for the whole burst.
- burst_write  out  1  memory write, held for the whole burst.
- burst_address  out  32  line-aligned burst base address.
- burst_wdata  out  BEAT_WIDTH  current write beat.
- burst_rdata  in  BEAT_WIDTH  read beat data, valid when burst_resp=1.
- burst_resp  in  1  beat accepted (write) or beat valid (read).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - state=IDLE, beat counter=0.
  - pmem_resp_cla=0, pmem_rdata_256_cla=0.
  - burst_read=0, burst_write=0, burst_address=0, burst_wdata=0.
  - Internal line buffers=0.
  - Reset mid-burst aborts immediately; no response is issued.
- States: IDLE, READ, WRITE, DONE. All memory-side outputs are registered or driven from registered state; no combinational path from burst_resp to burst_read/burst_write.
- IDLE:
  - If pmem_read_cla=1: capture {pmem_address_cla[31:OFFSET_BITS], OFFSET_BITS'b0} into the address register, clear the beat counter, go to READ.
  - Else if pmem_write_cla=1: also capture pmem_wdata_256_cla into the write buffer, go to WRITE.
  - Read and write both high: read wins; the write is not latched.
  - burst_resp in IDLE is ignored.
- READ:
  - burst_read=1, burst_address=captured address.
  - Each cycle with burst_resp=1: store burst_rdata into line slice [beat*BEAT_WIDTH +: BEAT_WIDTH], increment the counter.
  - Beat 0 is the lowest slice. Beats need not be consecutive; idle cycles (burst_resp=0) hold the state.
  - On the resp of beat BEATS-1, go to DONE.
- WRITE:
  - burst_write=1, burst_wdata = write buffer slice [beat*BEAT_WIDTH +: BEAT_WIDTH].
  - Counter advances on each burst_resp. The slice updates the same cycle the counter changes (combinational mux off the registered counter).
  - After beat BEATS-1 resp, go to DONE.
- DONE:
  - pmem_resp_cla=1 for exactly this one cycle; burst_read=burst_write=0.
  - pmem_rdata_256_cla presents the assembled line. It holds that value until the next read completes; it is not cleared by writes.
  - Unconditionally go to IDLE. Requests visible during DONE are not sampled.
- Latency: request seen in IDLE at cycle t; burst strobe high from t+1. With back-to-back memory responses, burst_resp occupies t+1..t+4, DONE at t+5, and a new request is accepted at t+6 at the earliest.
- Captured address and data are frozen for the burst; requester changes mid-burst have no effect.
- Counter wraps to 0 after the last beat. A burst_resp in DONE or IDLE does not advance the counter.

Test Plan:
- Read 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with back-to-back resp → burst_address=0x0000_1220 from t+1 to t+4; pmem_resp_cla single pulse at t+5; pmem_rdata_256_cla={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write 0x0000_0040, line={D3,D2,D1,D0}, memory resp with 2 idle cycles between beats → burst_wdata sequence D0,D1,D2,D3, each stable until its resp; burst_write held high throughout; one resp pulse after D3's resp.
- pmem_read_cla and pmem_write_cla both high in IDLE → READ burst only; no burst_write.
- Write completes after a read of line L → pmem_rdata_256_cla still equals L.
- rst asserted after beat 1 of a read → next cycle all outputs 0 and state IDLE, no pmem_resp_cla; a new read afterwards completes normally with fresh data.
- Stray burst_resp in IDLE, then a read → counter not advanced; all four beats land in the correct slices.

Source files
------------

// File: rtl/pmem_burst_sequencer_if.sv
// Line-request side and memory-burst side of the main-memory port.
// The sequencer takes the slave view; the arbiter/memory pair takes master.
interface pmem_burst_sequencer_if #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
);
    logic                  pmem_read_cla;
    logic                  pmem_write_cla;
    logic [31:0]           pmem_address_cla;
    logic [LINE_WIDTH-1:0] pmem_wdata_256_cla;
    logic                  pmem_resp_cla;
    logic [LINE_WIDTH-1:0] pmem_rdata_256_cla;
    logic                  burst_read;
    logic                  burst_write;
    logic [31:0]           burst_address;
    logic [BEAT_WIDTH-1:0] burst_wdata;
    logic [BEAT_WIDTH-1:0] burst_rdata;
    logic                  burst_resp;

    modport slave (
        input  pmem_read_cla,
        input  pmem_write_cla,
        input  pmem_address_cla,
        input  pmem_wdata_256_cla,
        output pmem_resp_cla,
        output pmem_rdata_256_cla,
        output burst_read,
        output burst_write,
        output burst_address,
        output burst_wdata,
        input  burst_rdata,
        input  burst_resp
    );

    modport master (
        output pmem_read_cla,
        output pmem_write_cla,
        output pmem_address_cla,
        output pmem_wdata_256_cla,
        input  pmem_resp_cla,
        input  pmem_rdata_256_cla,
        input  burst_read,
        input  burst_write,
        input  burst_address,
        input  burst_wdata,
        output burst_rdata,
        output burst_resp
    );
endinterface

// File: rtl/pmem_burst_sequencer.sv
// Splits one cacheline read/write into a fixed burst of memory beats
// and returns a single-cycle line response when the burst completes.
module pmem_burst_sequencer #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic clk,
    input  logic rst,
    pmem_burst_sequencer_if.slave bus
);
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      beat;
    logic [CNT_W-1:0]      beat_nxt;
    logic                  last_beat;
    logic [31:0]           addr_q;
    logic [LINE_WIDTH-1:0] wbuf_q;
    logic [LINE_WIDTH-1:0] rbuf_q;
    logic [LINE_WIDTH-1:0] rbuf_nxt;
    logic [LINE_WIDTH-1:0] rline_q;

    assign last_beat = bus.burst_resp && (beat == LAST);
    assign beat_nxt  = (beat == LAST) ? '0 : beat + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.pmem_read_cla)       state_nxt = READ;
                else if (bus.pmem_write_cla) state_nxt = WRITE;
            end
            READ:    if (last_beat) state_nxt = DONE;
            WRITE:   if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rbuf_nxt = rbuf_q;
        rbuf_nxt[int'(beat)*BEAT_WIDTH +: BEAT_WIDTH] = bus.burst_rdata;
    end

    // Read line is published only on the final beat so the response
    // value stays stable across later writes and partial reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat    <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
            rline_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.pmem_read_cla || bus.pmem_write_cla) begin
                        addr_q <= bus.pmem_address_cla & ALIGN_MASK;
                        beat   <= '0;
                        if (!bus.pmem_read_cla)
                            wbuf_q <= bus.pmem_wdata_256_cla;
                    end
                end
                READ: begin
                    if (bus.burst_resp) begin
                        rbuf_q <= rbuf_nxt;
                        beat   <= beat_nxt;
                        if (beat == LAST) rline_q <= rbuf_nxt;
                    end
                end
                WRITE: begin
                    if (bus.burst_resp) beat <= beat_nxt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.pmem_resp_cla      = (state == DONE);
        bus.pmem_rdata_256_cla = rline_q;
        bus.burst_read         = (state == READ);
        bus.burst_write        = (state == WRITE);
        bus.burst_address      = addr_q;
        bus.burst_wdata        = wbuf_q[int'(beat)*BEAT_WIDTH +: BEAT_WIDTH];
    end
endmodule

// File: tb/tb_pmem_burst_sequencer.sv
// Scoreboard bench: line requests push expected responses, a memory
// responder serves/checks beats, and a monitor checks each line response.
module tb_pmem_burst_sequencer;
    localparam int LW = 256;
    localparam int BW = 64;
    localparam int NB = LW / BW;

    logic clk;
    logic rst;

    pmem_burst_sequencer_if #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW)) bus ();

    pmem_burst_sequencer #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [LW-1:0] exp_q[$];
    logic [BW-1:0] rd_beat_q[$];
    logic [BW-1:0] wr_beat_q[$];
    logic [LW-1:0] last_line;
    logic [31:0]   cur_addr;
    int gap_min = 0;
    int gap_max = 0;
    bit stray_en = 0;
    int idle_left = 0;

    task automatic chk(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Line response monitor
    always @(negedge clk) begin
        if (!rst && bus.pmem_resp_cla === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                chk("line_rdata", bus.pmem_rdata_256_cla, exp_q.pop_front());
            end
        end
    end

    // Memory model: serves read beats, checks write beats and address
    always @(negedge clk) begin
        if (rst) begin
            bus.burst_resp = 1'b0;
            idle_left = 0;
        end else if (bus.burst_read || bus.burst_write) begin
            if (bus.burst_read && bus.burst_write)
                chk("rd_wr_both", 1, 0);
            if (idle_left > 0) begin
                bus.burst_resp = 1'b0;
                idle_left--;
                if (bus.burst_write && wr_beat_q.size() > 0)
                    chk("wdata_hold", LW'(bus.burst_wdata),
                        LW'(wr_beat_q[0]));
            end else begin
                bus.burst_resp = 1'b1;
                chk("burst_addr", LW'(bus.burst_address), LW'(cur_addr));
                if (bus.burst_read) begin
                    if (rd_beat_q.size() == 0) chk("extra_rd_beat", 1, 0);
                    else bus.burst_rdata = rd_beat_q.pop_front();
                end else begin
                    if (wr_beat_q.size() == 0) chk("extra_wr_beat", 1, 0);
                    else chk("wdata_beat", LW'(bus.burst_wdata),
                             LW'(wr_beat_q.pop_front()));
                end
                idle_left = $urandom_range(gap_max, gap_min);
            end
        end else begin
            idle_left = 0;
            bus.burst_resp = stray_en ? 1'($urandom % 2) : 1'b0;
            bus.burst_rdata = {$urandom, $urandom};
        end
    end

    task automatic do_req(input bit rd, input bit wr,
                          input logic [31:0] addr,
                          input logic [LW-1:0] line, output int lat);
        bit got = 0;
        cur_addr = addr & ~32'd31;
        if (rd) begin
            for (int i = 0; i < NB; i++)
                rd_beat_q.push_back(line[i*BW +: BW]);
            last_line = line;
            exp_q.push_back(line);
        end else if (wr) begin
            for (int i = 0; i < NB; i++)
                wr_beat_q.push_back(line[i*BW +: BW]);
            exp_q.push_back(last_line);
        end
        @(posedge clk);
        #1;
        bus.pmem_read_cla      = rd;
        bus.pmem_write_cla     = wr;
        bus.pmem_address_cla   = addr;
        bus.pmem_wdata_256_cla = line;
        lat = 0;
        while (!got && lat < 300) begin
            @(negedge clk);
            if (bus.pmem_resp_cla) got = 1;
            else lat++;
        end
        if (!got) chk("resp_timeout", 1, 0);
        @(posedge clk);
        #1;
        bus.pmem_read_cla  = 1'b0;
        bus.pmem_write_cla = 1'b0;
        bus.pmem_address_cla   = $urandom;
        bus.pmem_wdata_256_cla = rand_line();
    endtask

    initial begin
        int lat;
        logic [LW-1:0] l;
        logic [LW-1:0] outs;
        rst = 1'b1;
        last_line = '0;
        cur_addr = '0;
        bus.pmem_read_cla = 1'b0;
        bus.pmem_write_cla = 1'b0;
        bus.pmem_address_cla = '0;
        bus.pmem_wdata_256_cla = '0;
        bus.burst_rdata = '0;
        bus.burst_resp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs = {bus.pmem_resp_cla, bus.burst_read, bus.burst_write,
                bus.burst_address, bus.burst_wdata};
        chk("reset_outs", outs, '0);
        chk("reset_rdata", bus.pmem_rdata_256_cla, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // back-to-back read, latency check
        l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        do_req(1, 0, 32'h0000_1234, l, lat);
        chk("read_latency", LW'(lat), LW'(5));

        // write with two idle cycles between beats
        gap_min = 2; gap_max = 2;
        l = rand_line();
        do_req(0, 1, 32'h0000_0040, l, lat);
        gap_min = 0; gap_max = 0;

        // read and write together: read wins
        do_req(1, 1, 32'h0000_2008, rand_line(), lat);
        chk("both_latency", LW'(lat), LW'(5));
        do_req(0, 1, 32'h0000_3000, rand_line(), lat);

        // reset after beat 1 of a read
        cur_addr = 32'h0000_5000;
        l = rand_line();
        for (int i = 0; i < NB; i++) rd_beat_q.push_back(l[i*BW +: BW]);
        @(posedge clk);
        #1;
        bus.pmem_read_cla = 1'b1;
        bus.pmem_address_cla = 32'h0000_5010;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.pmem_read_cla = 1'b0;
        @(negedge clk);
        @(negedge clk);
        outs = {bus.pmem_resp_cla, bus.burst_read, bus.burst_write,
                bus.burst_address, bus.burst_wdata};
        chk("abort_outs", outs, '0);
        chk("abort_rdata", bus.pmem_rdata_256_cla, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        rd_beat_q.delete();
        last_line = '0;
        do_req(0, 1, 32'h0000_6000, rand_line(), lat);
        do_req(1, 0, 32'h0000_5010, rand_line(), lat);
        chk("post_abort_lat", LW'(lat), LW'(5));

        // stray responses while idle, then a read
        stray_en = 1;
        repeat (6) @(posedge clk);
        do_req(1, 0, 32'h0000_7fff, rand_line(), lat);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            bit rd;
            bit wr;
            rd = 1'($urandom % 2);
            wr = rd ? 1'($urandom % 4 == 0) : 1'b1;
            gap_min = 0;
            gap_max = $urandom_range(3, 0);
            stray_en = 1'($urandom % 2);
            do_req(rd, wr, $urandom, rand_line(), lat);
        end

        repeat (4) @(posedge clk);
        chk("exp_q_empty", LW'(exp_q.size()), '0);
        chk("rd_q_empty", LW'(rd_beat_q.size()), '0);
        chk("wr_q_empty", LW'(wr_beat_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
